// File: rtl/div_hilo_if.sv
// CPU-side port bundle of the HI/LO divide sequencer: request, MTHI/MTLO, results and status.
interface div_hilo_if #(
  parameter int WIDTH = 32
) ();
  // Handshake: a request is taken on a rising edge where req_valid && req_ready are both 1.
  // req_valid while req_ready is 0 is dropped, not held; the CPU must re-present it.
  logic             req_valid;
  logic             req_signed;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_ready;
  logic             abort;
  logic             mthi_we;
  logic             mtlo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             cpu_stall;
  logic             done;
  logic             dz_err;
  logic             to_err;

  modport master (
    output req_valid, req_signed, req_a, req_b, abort, mthi_we, mtlo_we, wdata,
    input  req_ready, hi, lo, cpu_stall, done, dz_err, to_err
  );

  modport slave (
    input  req_valid, req_signed, req_a, req_b, abort, mthi_we, mtlo_we, wdata,
    output req_ready, hi, lo, cpu_stall, done, dz_err, to_err
  );
endinterface

// File: rtl/div_hilo_ctrl.sv
// Sequencer between the execute stage and the shared multi-cycle divider; owns HI/LO,
// divide-by-zero, abort and timeout recovery.
module div_hilo_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic             clock,
  input  logic             reset_n,
  div_hilo_if.slave        cpu,
  output logic             div_start,
  output logic             div_signed,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_busy,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dz_q;
  logic             to_q;

  logic idle;
  logic accept;
  logic dz_req;
  logic go_div;
  logic timed_out;
  logic commit;
  logic wait_to;
  logic drain_end;
  logic drain_to;

  assign idle      = (state == S_IDLE);
  assign accept    = idle && cpu.req_valid;
  assign dz_req    = (cpu.req_b == '0);
  assign go_div    = accept && !dz_req;
  // >= rather than == so an abort taken on the last WAIT cycle still times out in DRAIN.
  assign timed_out = (timer >= T_LAST);

  // abort wins over both commit and timeout in WAIT; results are then drained.
  assign commit    = (state == S_WAIT) && !cpu.abort && !div_busy;
  assign wait_to   = (state == S_WAIT) && !cpu.abort && div_busy && timed_out;
  assign drain_end = (state == S_DRAIN) && !div_busy;
  assign drain_to  = (state == S_DRAIN) && div_busy && timed_out;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (go_div) state_d = S_START;
      S_START: state_d = cpu.abort ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (cpu.abort)             state_d = S_DRAIN;
        else if (commit || wait_to) state_d = S_IDLE;
      end
      S_DRAIN: if (drain_end || drain_to) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      timer <= '0;
    end else begin
      state <= state_d;
      if ((state == S_WAIT || state == S_DRAIN) && state_d != S_IDLE)
        timer <= timer + TW'(1);
      else
        timer <= '0;
    end
  end

  // Divider-side outputs are registered and held until the next accepted request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_start    <= 1'b0;
      div_signed   <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      div_start <= go_div;
      if (go_div) begin
        div_signed   <= cpu.req_signed;
        div_dividend <= cpu.req_a;
        div_divisor  <= cpu.req_b;
      end
    end
  end

  // Commits only happen outside IDLE and MT writes only inside it, so they never collide.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= div_r;
      lo_q <= div_q;
    end else if (idle) begin
      if (cpu.mthi_we) hi_q <= cpu.wdata;
      if (cpu.mtlo_we) lo_q <= cpu.wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      done_q <= commit || wait_to || (accept && dz_req);
      dz_q   <= accept && dz_req;
      to_q   <= wait_to || drain_to;
    end
  end

  assign cpu.req_ready = idle;
  assign cpu.cpu_stall = !idle;
  assign cpu.hi        = hi_q;
  assign cpu.lo        = lo_q;
  assign cpu.done      = done_q;
  assign cpu.dz_err    = dz_q;
  assign cpu.to_err    = to_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Self-checking bench for div_hilo_ctrl with a behavioural 32-cycle divider stub.
module tb_div_hilo_ctrl;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  div_hilo_if #(.WIDTH(32)) cpu ();

  logic        div_start;
  logic        div_signed;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_busy;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [1:0]  dbg_state;

  div_hilo_ctrl #(.WIDTH(32), .TIMEOUT(40)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cpu          (cpu),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_busy     (div_busy),
    .div_q        (div_q),
    .div_r        (div_r),
    .dbg_state    (dbg_state)
  );

  // ---------------- divider stub: busy from the start edge for 32 more edges ----------------
  logic       stub_busy;
  logic [5:0] stub_cnt;
  logic       tie_busy;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stub_busy <= 1'b0;
      stub_cnt  <= '0;
      div_q     <= '0;
      div_r     <= '0;
    end else if (div_start) begin
      stub_busy <= 1'b1;
      stub_cnt  <= '0;
      if (div_signed) begin
        div_q <= $signed(div_dividend) / $signed(div_divisor);
        div_r <= $signed(div_dividend) % $signed(div_divisor);
      end else begin
        div_q <= div_dividend / div_divisor;
        div_r <= div_dividend % div_divisor;
      end
    end else if (stub_busy) begin
      if (stub_cnt == 6'd31) stub_busy <= 1'b0;
      stub_cnt <= stub_cnt + 6'd1;
    end
  end
  assign div_busy = stub_busy | tie_busy;

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Truncating division from magnitudes: quotient sign = sign(a)^sign(b), remainder takes sign(a).
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
    logic [31:0] ma, mb, mq, mr;
    logic        na, nb;
    na = s & a[31];
    nb = s & b[31];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    mq = ma / mb;
    mr = ma % mb;
    q  = (na ^ nb) ? -mq : mq;
    r  = na ? -mr : mr;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    cpu.req_valid  = 1'b0;
    cpu.req_signed = 1'b0;
    cpu.req_a      = '0;
    cpu.req_b      = '0;
    cpu.abort      = 1'b0;
    cpu.mthi_we    = 1'b0;
    cpu.mtlo_we    = 1'b0;
    cpu.wdata      = '0;
  endtask

  task automatic mt_write(input logic hi_we, input logic lo_we, input logic [31:0] d);
    cpu.mthi_we = hi_we;
    cpu.mtlo_we = lo_we;
    cpu.wdata   = d;
    tick();
    cpu.mthi_we = 1'b0;
    cpu.mtlo_we = 1'b0;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic s);
    cpu.req_valid  = 1'b1;
    cpu.req_a      = a;
    cpu.req_b      = b;
    cpu.req_signed = s;
    tick();
    cpu.req_valid  = 1'b0;
  endtask

  // Follows one request to its done pulse; optional noise hammers req/MT inputs while stalled.
  task automatic collect(input bit noise, output bit saw_done, output logic dz, output logic to,
                         output int stall, output int starts);
    saw_done = 1'b0; dz = 1'b0; to = 1'b0; stall = 0; starts = 0;
    for (int i = 0; i < 100; i++) begin
      if (div_start) starts++;
      if (cpu.done) begin
        saw_done = 1'b1;
        dz = cpu.dz_err;
        to = cpu.to_err;
        break;
      end
      if (cpu.cpu_stall) stall++;
      if (noise && cpu.cpu_stall) begin
        cpu.req_valid = 1'b1;
        cpu.req_a     = $urandom;
        cpu.req_b     = $urandom;
        cpu.mthi_we   = 1'b1;
        cpu.mtlo_we   = 1'b1;
        cpu.wdata     = $urandom;
      end
      tick();
    end
    clear_inputs();
    if (!saw_done) $display("FAIL collect: no done within 100 cycles");
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
    int          exp_stall;
    int          exp_starts;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  initial begin
    bit          saw;
    logic        dz, to;
    int          stall, starts, n_done, n_to;
    logic [31:0] a, b, q, r, d;
    logic        s;
    logic [63:0] e;

    clear_inputs();
    tie_busy = 1'b0;

    vecs[0] = '{32'h0,  32'h0,  32'd100,      32'd7,        1'b1, 32'd2,        32'd14,       1'b0, 34, 1};
    vecs[1] = '{32'h0,  32'h0,  32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 34, 1};
    vecs[2] = '{32'h11, 32'h22, 32'd5,        32'd0,        1'b1, 32'h11,       32'h22,       1'b1, 0,  0};
    vecs[3] = '{32'h0,  32'h0,  32'hFFFFFF9C, 32'd7,        1'b0, 32'd2,        32'h24924916, 1'b0, 34, 1};
    vecs[4] = '{32'h5,  32'h6,  32'd100,      32'hFFFFFFF9, 1'b1, 32'd2,        32'hFFFFFFF2, 1'b0, 34, 1};
    vecs[5] = '{32'h0,  32'h0,  32'd5,        32'd10,       1'b0, 32'd5,        32'd0,        1'b0, 34, 1};
    vecs[6] = '{32'hAA, 32'hBB, 32'd0,        32'd0,        1'b0, 32'hAA,       32'hBB,       1'b1, 0,  0};
    vecs[7] = '{32'h0,  32'h0,  32'd9,        32'd2,        1'b0, 32'd1,        32'd4,        1'b0, 34, 1};

    // reset values
    repeat (3) @(posedge clock);
    #1;
    check("rst_hi", cpu.hi, 32'h0);
    check("rst_lo", cpu.lo, 32'h0);
    check("rst_ready", 32'(cpu.req_ready), 32'd1);
    check("rst_stall", 32'(cpu.cpu_stall), 32'd0);
    check("rst_flags", 32'({cpu.done, cpu.dz_err, cpu.to_err, div_start}), 32'd0);
    check("rst_div_regs", div_dividend | div_divisor | 32'(div_signed), 32'h0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset_n = 1'b1;
    tick();

    // table-driven vectors
    for (int i = 0; i < NV; i++) begin
      mt_write(1'b1, 1'b0, vecs[i].pre_hi);
      mt_write(1'b0, 1'b1, vecs[i].pre_lo);
      drive_req(vecs[i].a, vecs[i].b, vecs[i].sgn);
      collect(bit'(i % 2), saw, dz, to, stall, starts);
      check($sformatf("v%0d_done", i), 32'(saw), 32'd1);
      check($sformatf("v%0d_hi", i), cpu.hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), cpu.lo, vecs[i].exp_lo);
      check($sformatf("v%0d_dz", i), 32'(dz), 32'(vecs[i].exp_dz));
      check($sformatf("v%0d_to", i), 32'(to), 32'd0);
      check($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
      check($sformatf("v%0d_starts", i), 32'(starts), 32'(vecs[i].exp_starts));
      tick();
      check($sformatf("v%0d_done_pulse", i), 32'({cpu.done, cpu.dz_err}), 32'd0);
    end

    // MTHI and MTLO in the same cycle
    mt_write(1'b1, 1'b1, 32'h12345678);
    check("mt_both_hi", cpu.hi, 32'h12345678);
    check("mt_both_lo", cpu.lo, 32'h12345678);

    // request and MTHI together: MT lands now, the commit overwrites it
    cpu.mthi_we = 1'b1;
    cpu.wdata   = 32'h55;
    drive_req(32'd50, 32'd6, 1'b0);
    cpu.mthi_we = 1'b0;
    check("mt_with_req_hi", cpu.hi, 32'h55);
    collect(1'b0, saw, dz, to, stall, starts);
    check("mt_with_req_commit_hi", cpu.hi, 32'd2);
    check("mt_with_req_commit_lo", cpu.lo, 32'd8);

    // abort at WAIT cycle 5: no done, HI/LO untouched
    drive_req(32'd1000, 32'd3, 1'b0);
    repeat (6) tick();
    check("abort_in_wait_state", 32'(dbg_state), 32'd2);
    cpu.abort = 1'b1;
    tick();
    cpu.abort = 1'b0;
    check("abort_drain_state", 32'(dbg_state), 32'd3);
    n_done = 0;
    for (int i = 0; i < 100 && !cpu.req_ready; i++) begin
      if (cpu.done) n_done++;
      tick();
    end
    check("abort_ready", 32'(cpu.req_ready), 32'd1);
    check("abort_busy_fell", 32'(div_busy), 32'd0);
    check("abort_no_done", 32'(n_done + 32'(cpu.done)), 32'd0);
    check("abort_hi", cpu.hi, 32'd2);
    check("abort_lo", cpu.lo, 32'd8);
    drive_req(32'd9, 32'd2, 1'b1);
    collect(1'b0, saw, dz, to, stall, starts);
    check("after_abort_lo", cpu.lo, 32'd4);
    check("after_abort_hi", cpu.hi, 32'd1);

    // abort during START: the start pulse still issues, then drains
    drive_req(32'd77, 32'd5, 1'b0);
    starts = div_start ? 1 : 0;
    cpu.abort = 1'b1;
    tick();
    cpu.abort = 1'b0;
    n_done = 0;
    for (int i = 0; i < 100 && !cpu.req_ready; i++) begin
      if (div_start) starts++;
      if (cpu.done) n_done++;
      tick();
    end
    check("abort_start_starts", 32'(starts), 32'd1);
    check("abort_start_no_done", 32'(n_done), 32'd0);
    check("abort_start_ready", 32'(cpu.req_ready), 32'd1);
    check("abort_start_lo", cpu.lo, 32'd4);

    // asynchronous reset in the middle of WAIT
    drive_req(32'd100, 32'd7, 1'b1);
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_hi", cpu.hi, 32'h0);
    check("midrst_lo", cpu.lo, 32'h0);
    check("midrst_ready", 32'(cpu.req_ready), 32'd1);
    check("midrst_start", 32'(div_start), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // WAIT timeout with the divider stuck busy; MT writes while stalled are dropped
    mt_write(1'b1, 1'b0, 32'h77);
    mt_write(1'b0, 1'b1, 32'h88);
    tie_busy = 1'b1;
    drive_req(32'd20, 32'd3, 1'b0);
    collect(1'b1, saw, dz, to, stall, starts);
    check("to_done", 32'(saw), 32'd1);
    check("to_err", 32'(to), 32'd1);
    check("to_dz", 32'(dz), 32'd0);
    check("to_stall", 32'(stall), 32'd41);
    check("to_hi", cpu.hi, 32'h77);
    check("to_lo", cpu.lo, 32'h88);
    tick();
    check("to_pulse", 32'({cpu.done, cpu.to_err}), 32'd0);
    mt_write(1'b1, 1'b0, 32'hABCD);
    check("to_mthi_idle", cpu.hi, 32'hABCD);

    // DRAIN timeout: to_err without done
    drive_req(32'd20, 32'd3, 1'b0);
    cpu.abort = 1'b1;
    tick();
    cpu.abort = 1'b0;
    n_done = 0;
    n_to   = 0;
    for (int i = 0; i < 100 && !cpu.req_ready; i++) begin
      tick();
      if (cpu.done) n_done++;
      if (cpu.to_err) n_to++;
    end
    if (cpu.to_err && n_to == 0) n_to++;
    check("drain_to_err", 32'(n_to), 32'd1);
    check("drain_to_no_done", 32'(n_done), 32'd0);
    check("drain_to_lo", cpu.lo, 32'h88);
    tie_busy = 1'b0;
    repeat (40) tick();

    // randomized traffic against the reference model
    mt_write(1'b1, 1'b1, 32'h0);
    model_hi = '0;
    model_lo = '0;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        logic hw, lw;
        hw = 1'($urandom_range(0, 1));
        lw = 1'($urandom_range(0, 1));
        d  = $urandom;
        mt_write(hw, lw, d);
        if (hw) model_hi = d;
        if (lw) model_lo = d;
      end
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 7) == 0)      b = 32'd0;
      else if ($urandom_range(0, 2) == 0) b = $urandom_range(1, 20);
      else                                b = $urandom;
      if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      if (b != 0) begin
        ref_div(a, b, s, q, r);
        model_hi = r;
        model_lo = q;
      end
      exp_q.push_back({model_hi, model_lo});
      drive_req(a, b, s);
      collect(1'($urandom_range(0, 1)), saw, dz, to, stall, starts);
      e = exp_q.pop_front();
      check($sformatf("rnd%0d_hi", n), cpu.hi, e[63:32]);
      check($sformatf("rnd%0d_lo", n), cpu.lo, e[31:0]);
      check($sformatf("rnd%0d_dz", n), 32'(dz), 32'(b == 0));
      check($sformatf("rnd%0d_stall", n), 32'(stall), (b == 0) ? 32'd0 : 32'd34);
    end

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
